// File: rtl/vending_pkg.sv
// ----------------------------------------------------------------------------
// vending_pkg
// Shared constants for the vending controller:
//   - one-hot coin codes presented by the coin acceptor
//   - FSM state encoding (legacy-compatible localparam constants)
//   - price expressed in 25c units
//   - helper mapping a credit unit count (0..3) to its credit state
// ----------------------------------------------------------------------------
package vending_pkg;

    // Coin codes on the 5-bit one-hot coin bus; bit 4 is reserved.
    localparam logic [4:0] ZERO        = 5'b00000;
    localparam logic [4:0] QUARTER     = 5'b00001;
    localparam logic [4:0] FIFTY       = 5'b00010;
    localparam logic [4:0] SEVENTYFIVE = 5'b00100;
    localparam logic [4:0] DOLLAR      = 5'b01000;

    // State encoding. Credit states carry their credit in units of 25c.
    typedef logic [2:0] state_t;
    localparam state_t EMPTY = 3'd0;
    localparam state_t Q25   = 3'd1;
    localparam state_t Q50   = 3'd2;
    localparam state_t Q75   = 3'd3;
    localparam state_t VEND  = 3'd4;

    // Price in 25c units ($1.00).
    localparam logic [2:0] PRICE_UNITS = 3'd4;

    // Map a below-price credit (in units) to the state holding that credit.
    // Anything outside 0..3 is not a credit state and falls back to EMPTY.
    function automatic state_t units_to_state(input logic [2:0] units);
        state_t st;
        case (units)
            3'd0:    st = EMPTY;
            3'd1:    st = Q25;
            3'd2:    st = Q50;
            3'd3:    st = Q75;
            default: st = EMPTY;
        endcase
        return st;
    endfunction

endpackage : vending_pkg

// File: rtl/vending_coin_decode.sv
// ----------------------------------------------------------------------------
// vending_coin_decode
// Purely combinational coin classifier.
// Ports:
//   coin   in  [4:0] one-hot coin code from the acceptor
//   valid  out       exactly one of bits [3:0] set and bit 4 clear
//   units  out [2:0] coin value in 25c units (0 when invalid)
// ----------------------------------------------------------------------------
module vending_coin_decode
    import vending_pkg::*;
(
    input  logic [4:0] coin,
    output logic       valid,
    output logic [2:0] units
);

    // Only the four legal one-hot codes are accepted; zero, the reserved bit
    // and any multi-bit pattern all decode as "no coin".
    always_comb begin
        valid = 1'b0;
        units = 3'd0;
        case (coin)
            QUARTER: begin
                valid = 1'b1;
                units = 3'd1;
            end
            FIFTY: begin
                valid = 1'b1;
                units = 3'd2;
            end
            SEVENTYFIVE: begin
                valid = 1'b1;
                units = 3'd3;
            end
            DOLLAR: begin
                valid = 1'b1;
                units = 3'd4;
            end
            default: begin
                valid = 1'b0;
                units = 3'd0;
            end
        endcase
    end

endmodule : vending_coin_decode

// File: rtl/vending_moore.sv
// ----------------------------------------------------------------------------
// vending_moore
// Moore vending controller: accumulates credit in 25c units from one coin per
// clock and pulses dispense for one cycle once credit reaches $1.00.
// Overpayment is discarded. All outputs are flops loaded from the next-state
// decode, so they follow the state register exactly with no path from coin.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset, forces EMPTY
//   coin         in   [4:0] one-hot coin code, sampled every rising edge
//   empty        out  credit = 0
//   quarter      out  credit = 25c
//   fifty        out  credit = 50c
//   seventyfive  out  credit = 75c
//   dollar       out  VEND state
//   dispense     out  product release, high only in VEND
// ----------------------------------------------------------------------------
module vending_moore
    import vending_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] coin,
    output logic       empty,
    output logic       quarter,
    output logic       fifty,
    output logic       seventyfive,
    output logic       dollar,
    output logic       dispense
);

    state_t     state_r;
    state_t     next_state_s;
    logic       coin_valid_s;
    logic [2:0] coin_units_s;
    logic [2:0] credit_s;
    logic [2:0] sum_s;

    logic empty_r;
    logic quarter_r;
    logic fifty_r;
    logic seventyfive_r;
    logic dollar_r;
    logic dispense_r;

    vending_coin_decode u_coin_decode (
        .coin  (coin),
        .valid (coin_valid_s),
        .units (coin_units_s)
    );

    // Credit held by the current state; VEND counts as zero so the cycle
    // after a purchase starts from a clean slate while still taking a coin.
    always_comb begin
        credit_s = 3'd0;
        case (state_r)
            EMPTY:   credit_s = 3'd0;
            Q25:     credit_s = 3'd1;
            Q50:     credit_s = 3'd2;
            Q75:     credit_s = 3'd3;
            VEND:    credit_s = 3'd0;
            default: credit_s = 3'd0;
        endcase
    end

    // Next-state logic. Max sum is 3 + 4 = 7, so 3 bits never overflow.
    // Illegal encodings recover to EMPTY.
    always_comb begin
        sum_s        = credit_s + coin_units_s;
        next_state_s = state_r;
        if ((state_r != EMPTY) && (state_r != Q25) && (state_r != Q50) &&
            (state_r != Q75) && (state_r != VEND)) begin
            next_state_s = EMPTY;
        end else if (coin_valid_s) begin
            if (sum_s >= PRICE_UNITS) begin
                next_state_s = VEND;
            end else begin
                next_state_s = units_to_state(sum_s);
            end
        end else if (state_r == VEND) begin
            next_state_s = EMPTY;
        end else begin
            next_state_s = state_r;
        end
    end

    // State register and registered output decode of the incoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= EMPTY;
            empty_r       <= 1'b1;
            quarter_r     <= 1'b0;
            fifty_r       <= 1'b0;
            seventyfive_r <= 1'b0;
            dollar_r      <= 1'b0;
            dispense_r    <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            empty_r       <= (next_state_s == EMPTY);
            quarter_r     <= (next_state_s == Q25);
            fifty_r       <= (next_state_s == Q50);
            seventyfive_r <= (next_state_s == Q75);
            dollar_r      <= (next_state_s == VEND);
            dispense_r    <= (next_state_s == VEND);
        end
    end

    assign empty       = empty_r;
    assign quarter     = quarter_r;
    assign fifty       = fifty_r;
    assign seventyfive = seventyfive_r;
    assign dollar      = dollar_r;
    assign dispense    = dispense_r;

endmodule : vending_moore

// File: tb/tb_vending_moore.sv
// ----------------------------------------------------------------------------
// tb_vending_moore
// Directed table of {reset, coin, expected outputs} records applied one per
// clock, plus hand-written multi-cycle sequences for dispense timing,
// consecutive purchases and reset during credit.
// Expected output vector order: {empty, quarter, fifty, seventyfive, dollar,
// dispense}.
// ----------------------------------------------------------------------------
module tb_vending_moore;

    localparam logic [5:0] O_EMPTY = 6'b100000;
    localparam logic [5:0] O_Q25   = 6'b010000;
    localparam logic [5:0] O_Q50   = 6'b001000;
    localparam logic [5:0] O_Q75   = 6'b000100;
    localparam logic [5:0] O_VEND  = 6'b000011;

    localparam logic [4:0] C_0  = 5'b00000;
    localparam logic [4:0] C_Q  = 5'b00001;
    localparam logic [4:0] C_F  = 5'b00010;
    localparam logic [4:0] C_S  = 5'b00100;
    localparam logic [4:0] C_D  = 5'b01000;
    localparam logic [4:0] C_R4 = 5'b10000;
    localparam logic [4:0] C_2B = 5'b00011;

    typedef struct {
        logic       rst;
        logic [4:0] coin;
        logic [5:0] exp;
    } vec_t;

    localparam int NVEC = 30;

    logic       clk;
    logic       reset;
    logic [4:0] coin;
    logic       empty;
    logic       quarter;
    logic       fifty;
    logic       seventyfive;
    logic       dollar;
    logic       dispense;

    int checks;
    int errors;
    vec_t vecs [NVEC];

    vending_moore dut (
        .clk         (clk),
        .reset       (reset),
        .coin        (coin),
        .empty       (empty),
        .quarter     (quarter),
        .fifty       (fifty),
        .seventyfive (seventyfive),
        .dollar      (dollar),
        .dispense    (dispense)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {empty, quarter, fifty, seventyfive, dollar, dispense};
    endfunction

    task automatic check_vec(input string name, input logic [5:0] got,
                             input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Drive inputs on the falling edge, sample 1 time unit after rising edge.
    task automatic step(input logic r, input logic [4:0] c);
        @(negedge clk);
        reset = r;
        coin  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_onehot(input string name);
        check_int(name, $countones({empty, quarter, fifty, seventyfive, dollar}), 1);
    endtask

    initial begin
        int first_disp;
        int pulses;

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        coin   = C_Q;

        // Reset with quarter held: coin ignored.
        vecs[0]  = '{1'b1, C_Q,  O_EMPTY};
        vecs[1]  = '{1'b1, C_Q,  O_EMPTY};
        // Q F F Q F F Q 0
        vecs[2]  = '{1'b0, C_Q,  O_Q25};
        vecs[3]  = '{1'b0, C_F,  O_Q75};
        vecs[4]  = '{1'b0, C_F,  O_VEND};
        vecs[5]  = '{1'b0, C_Q,  O_Q25};
        vecs[6]  = '{1'b0, C_F,  O_Q75};
        vecs[7]  = '{1'b0, C_F,  O_VEND};
        vecs[8]  = '{1'b0, C_Q,  O_Q25};
        vecs[9]  = '{1'b0, C_0,  O_Q25};
        // Single dollar from EMPTY.
        vecs[10] = '{1'b1, C_0,  O_EMPTY};
        vecs[11] = '{1'b0, C_D,  O_VEND};
        vecs[12] = '{1'b0, C_0,  O_EMPTY};
        // Invalid codes in Q50.
        vecs[13] = '{1'b0, C_F,  O_Q50};
        vecs[14] = '{1'b0, C_R4, O_Q50};
        vecs[15] = '{1'b0, C_2B, O_Q50};
        vecs[16] = '{1'b0, C_0,  O_Q50};
        // Seventyfive twice: excess dropped.
        vecs[17] = '{1'b1, C_S,  O_EMPTY};
        vecs[18] = '{1'b0, C_S,  O_Q75};
        vecs[19] = '{1'b0, C_S,  O_VEND};
        vecs[20] = '{1'b0, C_0,  O_EMPTY};
        // Reset in Q75.
        vecs[21] = '{1'b0, C_S,  O_Q75};
        vecs[22] = '{1'b1, C_Q,  O_EMPTY};
        vecs[23] = '{1'b0, C_0,  O_EMPTY};
        // Back-to-back dollars, then VEND taking a quarter, then invalid in VEND.
        vecs[24] = '{1'b0, C_D,  O_VEND};
        vecs[25] = '{1'b0, C_D,  O_VEND};
        vecs[26] = '{1'b0, C_Q,  O_Q25};
        vecs[27] = '{1'b0, C_D,  O_VEND};
        vecs[28] = '{1'b0, C_2B, O_EMPTY};
        // Reset asserted while a dollar arrives.
        vecs[29] = '{1'b1, C_D,  O_EMPTY};

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].coin);
            check_vec($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Dispense timing: Q F F from reset, dispense must appear on the
        // third edge after the first coin; bounded search of 6 cycles.
        step(1'b1, C_0);
        first_disp = -1;
        for (int c = 1; c <= 6; c++) begin
            case (c)
                1:       step(1'b0, C_Q);
                2:       step(1'b0, C_F);
                3:       step(1'b0, C_F);
                default: step(1'b0, C_0);
            endcase
            if (dispense === 1'b1 && first_disp < 0) first_disp = c;
        end
        check_int("qff_dispense_cycle", first_disp, 3);

        // Fifty held high: each cycle is a new coin -> Q50, VEND, Q50, VEND.
        step(1'b1, C_0);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            step(1'b0, C_F);
            check_vec($sformatf("fifty_held%0d", c), outs(),
                      (c % 2 == 0) ? O_Q50 : O_VEND);
            if (dispense === 1'b1) pulses++;
        end
        check_int("fifty_held_pulses", pulses, 2);

        // Reset during Q75 build-up: no dispense, one-hot status every cycle.
        step(1'b1, C_0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            case (c)
                0:       step(1'b0, C_Q);
                1:       step(1'b0, C_F);
                2:       step(1'b1, C_Q);
                3:       step(1'b0, C_0);
                4:       step(1'b0, C_S);
                default: step(1'b1, C_D);
            endcase
            check_onehot($sformatf("reset_q75_onehot%0d", c));
            if (dispense === 1'b1) pulses++;
        end
        check_vec("reset_q75_final", outs(), O_EMPTY);
        check_int("reset_q75_pulses", pulses, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_vending_moore
